// File: rtl/rv32e_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv32e_mem_pkg
// Shared definitions for the RV32E memory arbiter slice:
//   state_t   - arbiter FSM state encodings (IDLE -> ISSUE -> RESP)
//   port_id_t - requester identifiers (loader, data port, instruction fetch)
// ---------------------------------------------------------------------------
package rv32e_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PORT_LD = 2'd0,
    PORT_DP = 2'd1,
    PORT_IF = 2'd2
  } port_id_t;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rv32e_rr_pick2.sv
// ---------------------------------------------------------------------------
// rv32e_rr_pick2
// Two-way round-robin picker. When both requests are pending, the side that
// was NOT granted last wins; a single pending request always wins.
// Ports:
//   req  [1:0] in   request vector (bit 0 = data port, bit 1 = fetch)
//   last       in   1 when index 1 was the most recent grant, 0 for index 0
//   gnt  [1:0] out  one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module rv32e_rr_pick2
  import rv32e_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant selection: ties go to the side that was not served most recently.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (last) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rv32e_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32e_mem_arbiter
// Shares one single-port synchronous RAM between the program loader (ld),
// the CPU data port (dp) and the CPU instruction fetch port (if). One access
// at a time is sequenced through IDLE -> ISSUE -> RESP. The loader always
// wins arbitration in IDLE; dp and if share the remainder round-robin.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ld_req/ld_we/ld_addr/ld_wdata -> ld_ack   loader request / completion
//   dp_req/dp_we/dp_addr/dp_wdata -> dp_ack   data-port request / completion
//   if_req/if_addr              -> if_ack     fetch (read-only) request
//   rdata                       read data, meaningful only while an ack is high
//   mem_en/mem_we/mem_addr/mem_wdata  RAM command (word address)
//   mem_rdata                   RAM read data, valid one cycle after mem_en
// ---------------------------------------------------------------------------
module rv32e_mem_arbiter
  import rv32e_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          dp_req,
  input  logic          dp_we,
  input  logic [31:0]   dp_addr,
  input  logic [DW-1:0] dp_wdata,
  output logic          dp_ack,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_r;
  state_t        next_state_s;
  port_id_t      gnt_port_r;
  port_id_t      rr_last_r;
  port_id_t      win_port_s;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic          any_req_s;
  logic [1:0]    rr_gnt_s;
  logic          lat_we_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          ld_ack_r;
  logic          dp_ack_r;
  logic          if_ack_r;
  logic          unused_addr_bits_s;

  // Byte-offset and out-of-range address bits are deliberately dropped.
  assign unused_addr_bits_s = ^{ld_addr[31:AW+2], ld_addr[1:0],
                                dp_addr[31:AW+2], dp_addr[1:0],
                                if_addr[31:AW+2], if_addr[1:0]};

  rv32e_rr_pick2 u_rr_pick2 (
    .req  ({if_req, dp_req}),
    .last (rr_last_r == PORT_IF),
    .gnt  (rr_gnt_s)
  );

  // Winner selection: loader first, otherwise the round-robin choice.
  always_comb begin
    any_req_s   = ld_req | dp_req | if_req;
    win_port_s  = PORT_LD;
    win_we_s    = 1'b0;
    win_addr_s  = {AW{1'b0}};
    win_wdata_s = {DW{1'b0}};
    if (ld_req) begin
      win_port_s  = PORT_LD;
      win_we_s    = ld_we;
      win_addr_s  = ld_addr[AW+1:2];
      win_wdata_s = ld_wdata;
    end else if (rr_gnt_s[0]) begin
      win_port_s  = PORT_DP;
      win_we_s    = dp_we;
      win_addr_s  = dp_addr[AW+1:2];
      win_wdata_s = dp_wdata;
    end else if (rr_gnt_s[1]) begin
      win_port_s  = PORT_IF;
      win_we_s    = 1'b0;
      win_addr_s  = if_addr[AW+1:2];
      win_wdata_s = {DW{1'b0}};
    end else begin
      win_port_s  = PORT_LD;
    end
  end

  // Next-state logic for the three-phase access sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_RESP;
      ST_RESP:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant/latch registers and registered RAM command and ack outputs.
  // The RAM command is loaded on the IDLE->ISSUE edge so it is present for
  // exactly the ISSUE cycle; acks are loaded on ISSUE->RESP for the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_port_r  <= PORT_LD;
      rr_last_r   <= PORT_IF;
      lat_we_r    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      ld_ack_r    <= 1'b0;
      dp_ack_r    <= 1'b0;
      if_ack_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ld_ack_r <= 1'b0;
          dp_ack_r <= 1'b0;
          if_ack_r <= 1'b0;
          if (any_req_s) begin
            gnt_port_r  <= win_port_s;
            lat_we_r    <= win_we_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= win_we_s;
            mem_addr_r  <= win_addr_s;
            mem_wdata_r <= win_wdata_s;
            // Loader grants do not disturb the dp/if rotation.
            if (win_port_s != PORT_LD) begin
              rr_last_r <= win_port_s;
            end
          end
        end
        ST_ISSUE: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          ld_ack_r <= (gnt_port_r == PORT_LD);
          dp_ack_r <= (gnt_port_r == PORT_DP);
          if_ack_r <= (gnt_port_r == PORT_IF);
        end
        ST_RESP: begin
          ld_ack_r <= 1'b0;
          dp_ack_r <= 1'b0;
          if_ack_r <= 1'b0;
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          ld_ack_r <= 1'b0;
          dp_ack_r <= 1'b0;
          if_ack_r <= 1'b0;
        end
      endcase
    end
  end

  // Read data passes straight from the RAM during RESP; writes return zero.
  always_comb begin
    rdata = {DW{1'b0}};
    if ((state_r == ST_RESP) && !lat_we_r) begin
      rdata = mem_rdata;
    end else begin
      rdata = {DW{1'b0}};
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign ld_ack    = ld_ack_r;
  assign dp_ack    = dp_ack_r;
  assign if_ack    = if_ack_r;

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32e_mem_arbiter
// Directed bench with a behavioural RAM. Each stimulus pushes the expected
// (port, rdata) pair into a queue; a negedge monitor pops and compares
// whenever any ack is high, and flags overlapping or unexpected acks.
// ---------------------------------------------------------------------------
module tb_rv32e_mem_arbiter;

  localparam logic [1:0] P_LD = 2'd0;
  localparam logic [1:0] P_DP = 2'd1;
  localparam logic [1:0] P_IF = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_we, dp_req, dp_we, if_req;
  logic [31:0] ld_addr, dp_addr, if_addr;
  logic [31:0] ld_wdata, dp_wdata;
  logic        ld_ack, dp_ack, if_ack;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ack_cnt = 0;

  always #5 clk = ~clk;

  rv32e_mem_arbiter #(.AW(10), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .dp_req    (dp_req),
    .dp_we     (dp_we),
    .dp_addr   (dp_addr),
    .dp_wdata  (dp_wdata),
    .dp_ack    (dp_ack),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural single-port synchronous RAM (read-before-write).
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard monitor: one comparison per cycle in which any ack is high.
  always @(negedge clk) begin
    int         n;
    logic [1:0] ap;
    exp_t       e;
    if (!reset) begin
      n = int'(ld_ack) + int'(dp_ack) + int'(if_ack);
      if (n > 0) begin
        checks++;
        ack_cnt++;
        ap = ld_ack ? P_LD : (dp_ack ? P_DP : P_IF);
        if (n > 1) begin
          errors++;
          $display("FAIL ack_overlap: ld=%0b dp=%0b if=%0b, required at most one ack",
                   ld_ack, dp_ack, if_ack);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: port %0d acked with no outstanding request", ap);
        end else begin
          e = exp_q.pop_front();
          if (ap !== e.port || rdata !== e.data) begin
            errors++;
            $display("FAIL ack_scoreboard: got port %0d rdata 0x%08h, required port %0d rdata 0x%08h",
                     ap, rdata, e.port, e.data);
          end
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_ack(input logic [1:0] p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (ack_cnt < target && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (ack_cnt < target) begin
      errors++;
      $display("FAIL %s: saw %0d acks, required %0d before timeout", name, ack_cnt, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0000_0000;
    ram[4]  = 32'hDEAD_BEEF;
    ram[16] = 32'h1111_1111;
    ram[17] = 32'h2222_2222;
    reset = 1'b1;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    dp_req = 1'b0; dp_we = 1'b0; dp_addr = 32'h0; dp_wdata = 32'h0;
    if_req = 1'b0; if_addr = 32'h0;

    // Reset state
    step();
    chk("rst_ld_ack", {31'd0, ld_ack}, 32'd0);
    chk("rst_dp_ack", {31'd0, dp_ack}, 32'd0);
    chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    step();

    // Single fetch of 0x10: ISSUE next cycle, ack the cycle after
    if_req = 1'b1; if_addr = 32'h0000_0010;
    expect_ack(P_IF, 32'hDEAD_BEEF);
    step();
    chk("t1_issue_en", {31'd0, mem_en}, 32'd1);
    chk("t1_issue_we", {31'd0, mem_we}, 32'd0);
    chk("t1_issue_addr", {22'd0, mem_addr}, 32'd4);
    chk("t1_no_early_ack", {31'd0, if_ack}, 32'd0);
    step();
    chk("t1_ack_latency", {31'd0, if_ack}, 32'd1);
    chk("t1_en_dropped", {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    step();
    chk("t1_ack_one_cycle", {31'd0, if_ack}, 32'd0);

    // dp and if held together: rr_last is IF, so dp, if, dp, if
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 32'h0000_0040;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    expect_ack(P_DP, 32'h1111_1111);
    expect_ack(P_IF, 32'h2222_2222);
    expect_ack(P_DP, 32'h1111_1111);
    expect_ack(P_IF, 32'h2222_2222);
    wait_acks(ack_cnt + 4, "t3_rr_acks");
    dp_req = 1'b0; if_req = 1'b0;
    step();

    // dp write 0x20 then read back
    dp_req = 1'b1; dp_we = 1'b1; dp_addr = 32'h0000_0020; dp_wdata = 32'h1234_5678;
    expect_ack(P_DP, 32'h0000_0000);
    step();
    chk("t2_wr_we_issue", {31'd0, mem_we}, 32'd1);
    chk("t2_wr_addr", {22'd0, mem_addr}, 32'd8);
    chk("t2_wr_wdata", mem_wdata, 32'h1234_5678);
    step();
    chk("t2_wr_we_resp", {31'd0, mem_we}, 32'd0);
    chk("t2_wr_ack", {31'd0, dp_ack}, 32'd1);
    dp_req = 1'b0; dp_we = 1'b0;
    step();
    chk("t2_we_idle", {31'd0, mem_we}, 32'd0);
    dp_req = 1'b1;
    expect_ack(P_DP, 32'h1234_5678);
    step();
    chk("t2_rd_we_issue", {31'd0, mem_we}, 32'd0);
    step();
    chk("t2_rd_ack", {31'd0, dp_ack}, 32'd1);
    dp_req = 1'b0;
    step();

    // Loader raised during dp ISSUE: dp completes, then ld beats pending if
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 32'h0000_0020;
    expect_ack(P_DP, 32'h1234_5678);
    expect_ack(P_LD, 32'hDEAD_BEEF);
    expect_ack(P_IF, 32'h2222_2222);
    step();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0000_0010;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    wait_acks(ack_cnt + 1, "t4_dp_ack");
    dp_req = 1'b0;
    wait_acks(ack_cnt + 1, "t4_ld_ack");
    ld_req = 1'b0;
    wait_acks(ack_cnt + 1, "t4_if_ack");
    if_req = 1'b0;
    step();

    // Reset pulsed during ISSUE of a fetch: no ack, mem_en drops at once
    if_req = 1'b1; if_addr = 32'h0000_0010;
    step();
    chk("t5_issue_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_async_en", {31'd0, mem_en}, 32'd0);
    chk("t5_async_we", {31'd0, mem_we}, 32'd0);
    if_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("t5_no_ack", {31'd0, if_ack}, 32'd0);
    chk("t5_queue_empty", exp_q.size(), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0044;
    expect_ack(P_IF, 32'h2222_2222);
    step();
    chk("t5_next_en", {31'd0, mem_en}, 32'd1);
    chk("t5_next_addr", {22'd0, mem_addr}, 32'd17);
    step();
    chk("t5_next_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    step();

    // Fetch dropped and address changed after grant
    if_req = 1'b1; if_addr = 32'h0000_0040;
    expect_ack(P_IF, 32'h1111_1111);
    step();
    if_req = 1'b0; if_addr = 32'h0000_0044;
    chk("t6_latched_addr", {22'd0, mem_addr}, 32'd16);
    step();
    chk("t6_ack_after_drop", {31'd0, if_ack}, 32'd1);
    step();

    // Loader write with junk high/low address bits, then dp read of that word
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'hFFFF_F0C3; ld_wdata = 32'hCAFE_F00D;
    expect_ack(P_LD, 32'h0000_0000);
    step();
    chk("t7_addr_mask", {22'd0, mem_addr}, 32'd48);
    chk("t7_we", {31'd0, mem_we}, 32'd1);
    step();
    chk("t7_ld_ack", {31'd0, ld_ack}, 32'd1);
    ld_req = 1'b0; ld_we = 1'b0;
    step();
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 32'h0000_00C0;
    expect_ack(P_DP, 32'hCAFE_F00D);
    wait_acks(ack_cnt + 1, "t7_dp_ack");
    dp_req = 1'b0;
    step();
    step();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
